// File: rtl/switch_input_debouncer.sv
// rtl/switch_input_debouncer.sv - two-stage synchroniser, tick-based per-bit debouncer and edge pulses for slide switches
//
// Purpose:
//   Conditions raw slide-switch levels for a read-only input PIO. Each line is
//   synchronised, then debounced independently: a new level is accepted only
//   after STABLE_TICKS consecutive prescaler ticks in which the synchronised
//   input differs from the current debounced level, with no intervening cycle
//   where the two agree. Acceptance produces one-cycle rise/fall pulses and a
//   single aggregate changed pulse.
//
// Ports:
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous assert, active-low reset
//   raw_in      in   WIDTH  raw switch levels, asynchronous to clk
//   db_out      out  WIDTH  debounced levels, registered
//   rise_pulse  out  WIDTH  1-cycle pulse when db_out[i] goes 0->1
//   fall_pulse  out  WIDTH  1-cycle pulse when db_out[i] goes 1->0
//   changed     out  1      1-cycle pulse coincident with any rise/fall pulse
//   tick        out  1      prescaler tick, 1 cycle every TICK_DIV cycles

module switch_input_debouncer #(
  parameter int WIDTH        = 18,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed,
  output logic             tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [PW-1:0]    r_pre;
  logic             r_tick;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;

  logic [PW-1:0]    w_pre_next;
  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_db_next;
  logic [WIDTH-1:0] w_rise_next;
  logic [WIDTH-1:0] w_fall_next;

  // Two-flop synchroniser; only r_sync2 is used downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // r_tick is registered from the next count so that it is high exactly
  // while r_pre == TICK_DIV-1, yet still reads 0 during reset when TICK_DIV=1.
  always_comb begin
    w_pre_next = '0;
    if (r_pre != P_LAST) begin
      w_pre_next = r_pre + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= w_pre_next;
      r_tick <= (w_pre_next == P_LAST);
    end
  end

  // Per-bit qualification. Any cycle where the input agrees with the
  // debounced level clears the count, so a bounce restarts qualification.
  always_comb begin
    w_db_next   = r_db;
    w_rise_next = '0;
    w_fall_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (r_sync2[i] == r_db[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_tick) begin
        if (r_cnt[i] == C_LAST) begin
          w_db_next[i]   = r_sync2[i];
          w_cnt_next[i]  = '0;
          w_rise_next[i] = r_sync2[i];
          w_fall_next[i] = ~r_sync2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
      r_db      <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      r_db      <= w_db_next;
      r_rise    <= w_rise_next;
      r_fall    <= w_fall_next;
      r_changed <= |(w_rise_next | w_fall_next);
    end
  end

  assign db_out     = r_db;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign changed    = r_changed;
  assign tick       = r_tick;

endmodule

// File: tb/tb_switch_input_debouncer.sv
// tb/tb_switch_input_debouncer.sv - self-checking bench for switch_input_debouncer

module tb_switch_input_debouncer;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] raw_in;
  logic [W-1:0] db_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic         changed;
  logic         tick;

  int n_checks = 0;
  int n_fail   = 0;

  switch_input_debouncer #(
    .WIDTH(W),
    .TICK_DIV(TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .raw_in(raw_in),
    .db_out(db_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .changed(changed),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchronised input is raw_in delayed two clocks;
  // tick is seen after every TD-th edge since reset; a level is accepted once
  // it has disagreed with the debounced value across ST ticks in a row with
  // no agreeing cycle in between.
  logic [W-1:0] m_s1, m_s2, m_db, m_rise, m_fall;
  logic         m_chg, m_tick;
  int           m_run [W];
  int           m_edges;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
      m_chg = 1'b0; m_tick = 1'b0; m_edges = 0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_db[i]) begin
          m_run[i] = 0;
        end else if (m_tick) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == ST) begin
            m_db[i] = m_s2[i];
            m_run[i] = 0;
            if (m_s2[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
          end
        end
      end
      m_chg   = |(m_rise | m_fall);
      m_s2    = m_s1;
      m_s1    = raw_in;
      m_edges = m_edges + 1;
      m_tick  = ((m_edges + 1) % TD) == 0;
    end
  end

  int n_tick = 0;
  int n_chg  = 0;
  int n_rise [W];
  int n_fall [W];

  initial begin
    for (int i = 0; i < W; i++) begin
      n_rise[i] = 0;
      n_fall[i] = 0;
    end
    @(negedge clk);
    forever begin
      @(negedge clk);
      chk("db_out", 32'(db_out), 32'(m_db));
      chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
      chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
      chk("changed", 32'(changed), 32'(m_chg));
      chk("tick", 32'(tick), 32'(m_tick));
      if (tick === 1'b1) n_tick++;
      if (changed === 1'b1) n_chg++;
      for (int i = 0; i < W; i++) begin
        if (rise_pulse[i] === 1'b1) n_rise[i]++;
        if (fall_pulse[i] === 1'b1) n_fall[i]++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_change(input int b, input logic exp_val,
                             input logic [W-1:0] exp_rise, input logic [W-1:0] exp_fall);
    int n;
    n = 0;
    while (n < 30 && db_out[b] !== exp_val) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n < 11 || n > 14) begin
      n_fail++;
      $display("FAIL latency bit %0d: got %0d cycles expected 11..14", b, n);
    end
    chk("edge rise_pulse", 32'(rise_pulse), 32'(exp_rise));
    chk("edge fall_pulse", 32'(fall_pulse), 32'(exp_fall));
    chk("edge changed", 32'(changed), 32'd1);
    @(negedge clk);
    chk("after rise_pulse", 32'(rise_pulse), 32'd0);
    chk("after fall_pulse", 32'(fall_pulse), 32'd0);
    chk("after changed", 32'(changed), 32'd0);
  endtask

  initial begin
    int base_chg;
    int base_r1;
    int base_f1;
    int n;

    reset_n = 1'b0;
    raw_in  = '0;
    wait_cycles(3);
    step();
    reset_n = 1'b1;

    // 1: idle, tick every 4th cycle
    base_chg = n_chg;
    n = n_tick;
    wait_cycles(100);
    chk("idle tick count", 32'(n_tick - n), 32'd25);
    chk("idle changed count", 32'(n_chg - base_chg), 32'd0);
    chk("idle db_out", 32'(db_out), 32'd0);

    // 2: single rise
    step();
    raw_in = 4'b0001;
    wait_change(0, 1'b1, 4'b0001, 4'b0000);
    step();
    raw_in = 4'b0000;
    wait_cycles(20);
    chk("bit0 released", 32'(db_out), 32'd0);

    // 3: bounce shorter than qualification window is rejected
    base_chg = n_chg;
    base_r1  = n_rise[1];
    base_f1  = n_fall[1];
    for (int k = 0; k < 10; k++) begin
      step();
      raw_in[1] = ~raw_in[1];
      wait_cycles(5);
    end
    wait_cycles(20);
    chk("bounce db_out", 32'(db_out), 32'd0);
    chk("bounce rise count", 32'(n_rise[1] - base_r1), 32'd0);
    chk("bounce fall count", 32'(n_fall[1] - base_f1), 32'd0);
    chk("bounce changed count", 32'(n_chg - base_chg), 32'd0);

    // 4: fall on bit 2
    step();
    raw_in = 4'b0100;
    wait_cycles(20);
    chk("settled 0100", 32'(db_out), 32'h4);
    step();
    raw_in = 4'b0000;
    wait_change(2, 1'b0, 4'b0000, 4'b0100);

    // 5: all bits together
    wait_cycles(5);
    base_chg = n_chg;
    step();
    raw_in = 4'b1111;
    n = 0;
    while (n < 30 && db_out === 4'b0000) begin
      @(negedge clk);
      n++;
    end
    chk("all db_out", 32'(db_out), 32'hF);
    chk("all rise_pulse", 32'(rise_pulse), 32'hF);
    chk("all changed", 32'(changed), 32'd1);
    n_checks++;
    if (n < 11 || n > 14) begin
      n_fail++;
      $display("FAIL latency all: got %0d cycles expected 11..14", n);
    end
    wait_cycles(3);
    chk("all single changed", 32'(n_chg - base_chg), 32'd1);

    // 6: reset mid-qualification, switch held through reset
    step();
    raw_in = 4'b0000;
    wait_cycles(20);
    chk("cleared before reset", 32'(db_out), 32'd0);
    step();
    raw_in = 4'b1000;
    wait_cycles(5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset db_out", 32'(db_out), 32'd0);
    chk("reset pulses", 32'({rise_pulse, fall_pulse, changed, tick}), 32'd0);
    wait_cycles(2);
    #2;
    reset_n = 1'b1;
    wait_change(3, 1'b1, 4'b1000, 4'b0000);
    wait_cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
